// File: rtl/csi_cin_framer.sv
// Input framer for the CSI packetizer: tags raw words with sof/sol/eol/eof and buffers them
// in a show-ahead FIFO. Optional drop counter enabled by CSI_CIN_FRAMER_DROP_CNT_EN.
module csi_cin_framer #(
   parameter int P_CIN_DATA_WIDTH = 32,
   parameter int P_FIFO_DEPTH     = 16,
   parameter int P_CNT_WIDTH      = 16
) (
   input  logic                          csi_clk,
   input  logic                          rst_n,
   input  logic                          cfg_en,
   input  logic [P_CNT_WIDTH-1:0]        cfg_line_words,
   input  logic [P_CNT_WIDTH-1:0]        cfg_lines,
   input  logic [P_CIN_DATA_WIDTH-1:0]   cin_data,
   input  logic                          cin_valid,
   output logic [P_CIN_DATA_WIDTH-1:0]   data,
   output logic                          valid,
   input  logic                          ready,
   output logic                          sof,
   output logic                          sol,
   output logic                          eol,
   output logic                          eof,
   output logic                          ovf,
   input  logic                          ovf_clr,
   output logic [$clog2(P_FIFO_DEPTH):0] level
`ifdef CSI_CIN_FRAMER_DROP_CNT_EN
  ,output logic [15:0]                   drop_cnt
`endif
);

   localparam int AW = $clog2(P_FIFO_DEPTH);
   localparam int EW = P_CIN_DATA_WIDTH + 4;
   localparam int CW = P_CNT_WIDTH;

   typedef enum logic {IDLE, RUN} state_e;

   state_e          state_q, state_d;
   logic [CW-1:0]   word_idx_q, word_idx_d;
   logic [CW-1:0]   line_idx_q, line_idx_d;
   logic [CW-1:0]   lw_last, ln_last;
   logic            t_sof, t_sol, t_eol, t_eof;

   logic [EW-1:0]   mem_q [P_FIFO_DEPTH];
   logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
   logic [AW:0]     level_q, level_d;
   logic            ovf_q, ovf_d;
   logic            full, pop, push_req, push, drop;

   // A zero config is treated as one word/line, so the last index is 0 in both cases.
   assign lw_last = (cfg_line_words == '0) ? '0 : cfg_line_words - CW'(1);
   assign ln_last = (cfg_lines == '0)      ? '0 : cfg_lines - CW'(1);

   assign t_sol = (word_idx_q == '0);
   assign t_eol = (word_idx_q == lw_last);
   assign t_sof = t_sol & (line_idx_q == '0);
   assign t_eof = t_eol & (line_idx_q == ln_last);

   assign valid    = (level_q != '0);
   assign full     = (level_q == (AW+1)'(P_FIFO_DEPTH));
   assign pop      = valid & ready;
   assign push_req = (state_q == RUN) & cin_valid;
   assign push     = push_req & (~full | pop);
   assign drop     = push_req & full & ~pop;

   always_comb begin
      state_d    = state_q;
      word_idx_d = word_idx_q;
      line_idx_d = line_idx_q;
      case (state_q)
         IDLE: begin
            word_idx_d = '0;
            line_idx_d = '0;
            if (cfg_en) state_d = RUN;
         end
         RUN: begin
            // Counters advance on drops too, keeping framing aligned to the source.
            if (push_req) begin
               if (t_eol) begin
                  word_idx_d = '0;
                  line_idx_d = t_eof ? '0 : line_idx_q + CW'(1);
               end else begin
                  word_idx_d = word_idx_q + CW'(1);
               end
            end
            if (!cfg_en) begin
               state_d    = IDLE;
               word_idx_d = '0;
               line_idx_d = '0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      level_d = level_q + (AW+1)'(push) - (AW+1)'(pop);
      ovf_d   = ovf_q;
      if (ovf_clr) ovf_d = 1'b0;
      if (drop)    ovf_d = 1'b1;
   end

   always_ff @(posedge csi_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         word_idx_q <= '0;
         line_idx_q <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         ovf_q      <= 1'b0;
         for (int i = 0; i < P_FIFO_DEPTH; i++) mem_q[i] <= '0;
      end else begin
         state_q    <= state_d;
         word_idx_q <= word_idx_d;
         line_idx_q <= line_idx_d;
         level_q    <= level_d;
         ovf_q      <= ovf_d;
         if (push) begin
            mem_q[wr_ptr_q] <= {t_sof, t_sol, t_eol, t_eof, cin_data};
            wr_ptr_q        <= wr_ptr_q + AW'(1);
         end
         if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      end
   end

   assign {sof, sol, eol, eof, data} = mem_q[rd_ptr_q];
   assign ovf   = ovf_q;
   assign level = level_q;

`ifdef CSI_CIN_FRAMER_DROP_CNT_EN
   logic [15:0] drop_cnt_q, drop_cnt_d;

   always_comb begin
      drop_cnt_d = drop_cnt_q;
      if (drop) begin
         if (ovf_clr)                    drop_cnt_d = 16'd1;
         else if (drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
      end else if (ovf_clr) begin
         drop_cnt_d = '0;
      end
   end

   always_ff @(posedge csi_clk or negedge rst_n) begin
      if (!rst_n) drop_cnt_q <= '0;
      else        drop_cnt_q <= drop_cnt_d;
   end

   assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_csi_cin_framer.sv
// Directed bench for csi_cin_framer: a per-cycle vector table for basic framing, then
// hand-written sequences for overflow, full-throughput, zero config, disable and reset.
module tb_csi_cin_framer;

   logic        csi_clk = 1'b0;
   logic        rst_n;
   logic        cfg_en;
   logic [15:0] cfg_line_words, cfg_lines;
   logic [31:0] cin_data;
   logic        cin_valid;
   logic [31:0] data;
   logic        valid, ready;
   logic        sof, sol, eol, eof;
   logic        ovf, ovf_clr;
   logic [4:0]  level;
`ifdef CSI_CIN_FRAMER_DROP_CNT_EN
   logic [15:0] drop_cnt;
`endif

   int n_chk = 0;
   int n_pass = 0;

   always #5 csi_clk = ~csi_clk;

   csi_cin_framer dut (
      .csi_clk(csi_clk), .rst_n(rst_n), .cfg_en(cfg_en),
      .cfg_line_words(cfg_line_words), .cfg_lines(cfg_lines),
      .cin_data(cin_data), .cin_valid(cin_valid),
      .data(data), .valid(valid), .ready(ready),
      .sof(sof), .sol(sol), .eol(eol), .eof(eof),
      .ovf(ovf), .ovf_clr(ovf_clr), .level(level)
`ifdef CSI_CIN_FRAMER_DROP_CNT_EN
     ,.drop_cnt(drop_cnt)
`endif
   );

   typedef struct {
      logic        en, cv, rdy;
      logic [31:0] d;
      logic        vld;
      logic [3:0]  tags;
      logic [31:0] q;
      logic [4:0]  lvl;
   } vec_t;

   vec_t tbl[10];

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, got, exp);
   endtask

   task automatic tick();
      @(posedge csi_clk);
      #1;
   endtask

   logic [3:0] tag_exp [8];

   initial begin
      tag_exp = '{4'b1100, 4'b0000, 4'b0000, 4'b0010, 4'b0100, 4'b0000, 4'b0000, 4'b0011};
      tbl[0] = '{en:1, cv:0, rdy:1, d:0, vld:0, tags:0, q:0, lvl:0};
      for (int k = 1; k <= 8; k++)
         tbl[k] = '{en:1, cv:1, rdy:1, d:32'(k-1), vld:1, tags:tag_exp[k-1], q:32'(k-1), lvl:1};
      tbl[9] = '{en:1, cv:0, rdy:1, d:0, vld:0, tags:0, q:0, lvl:0};

      rst_n = 1'b0; cfg_en = 0; cfg_line_words = 16'd4; cfg_lines = 16'd2;
      cin_data = 0; cin_valid = 0; ready = 0; ovf_clr = 0;
      #12;
      chk("reset_state", {valid, sof, sol, eol, eof, ovf, level, data},
          {1'b0, 4'b0, 1'b0, 5'd0, 32'd0});
      rst_n = 1'b1;
      tick();

      // Test 1: table of per-cycle vectors
      foreach (tbl[i]) begin
         cfg_en = tbl[i].en; cin_valid = tbl[i].cv; cin_data = tbl[i].d; ready = tbl[i].rdy;
         tick();
         if (tbl[i].vld)
            chk($sformatf("t1_row%0d", i), {valid, sof, sol, eol, eof, data, level},
                {1'b1, tbl[i].tags, tbl[i].q, tbl[i].lvl});
         else
            chk($sformatf("t1_row%0d", i), {valid, level}, {1'b0, tbl[i].lvl});
      end
      cin_valid = 0;

      // Test 2: overflow with ready low
      ready = 0;
      for (int k = 0; k < 20; k++) begin
         cin_valid = 1; cin_data = 100 + k; tick();
      end
      cin_valid = 0;
      chk("t2_level_full", level, 16);
      chk("t2_ovf_set", ovf, 1);
      ready = 1;
      for (int k = 0; k < 16; k++) begin
         chk($sformatf("t2_drain%0d", k), {valid, data}, {1'b1, 32'(100 + k)});
         tick();
      end
      chk("t2_empty", {valid, level}, {1'b0, 5'd0});
      chk("t2_ovf_sticky", ovf, 1);
`ifdef CSI_CIN_FRAMER_DROP_CNT_EN
      chk("t2_drop_cnt", drop_cnt, 4);
`endif
      ovf_clr = 1; tick(); ovf_clr = 0;
      chk("t2_ovf_clr", ovf, 0);
`ifdef CSI_CIN_FRAMER_DROP_CNT_EN
      chk("t2_drop_cnt_clr", drop_cnt, 0);
`endif

      // Test 3: full FIFO with simultaneous push and pop
      ready = 0;
      for (int k = 0; k < 16; k++) begin
         cin_valid = 1; cin_data = 200 + k; tick();
      end
      ready = 1;
      for (int k = 0; k < 10; k++) begin
         cin_valid = 1; cin_data = 300 + k;
         chk($sformatf("t3_out%0d", k), data, 32'(200 + k));
         tick();
         chk($sformatf("t3_lvl_ovf%0d", k), {level, ovf}, {5'd16, 1'b0});
      end
      cin_valid = 0;
      for (int k = 0; k < 16; k++) begin
         chk($sformatf("t3_drain%0d", k), {valid, data},
             {1'b1, (k < 6) ? 32'(210 + k) : 32'(300 + k - 6)});
         tick();
      end
      chk("t3_empty", level, 0);

      // Test 4: zero config -> every word is a one-word frame
      cfg_en = 0; tick();
      cfg_line_words = 0; cfg_lines = 0; cfg_en = 1; tick();
      for (int k = 0; k < 3; k++) begin
         cin_valid = 1; cin_data = 400 + k; tick();
         chk($sformatf("t4_word%0d", k), {valid, sof, sol, eol, eof, data, level},
             {1'b1, 4'b1111, 32'(400 + k), 5'd1});
      end
      cin_valid = 0; tick();

      // Test 5: disable mid-line; queued words drain, idle input dropped silently
      cfg_en = 0; tick();
      cfg_line_words = 4; cfg_lines = 2; cfg_en = 1; tick();
      ready = 0;
      for (int k = 0; k < 6; k++) begin
         cin_valid = 1; cin_data = 500 + k; tick();
      end
      cin_valid = 0; cfg_en = 0; tick();
      cin_valid = 1; cin_data = 32'hdead;
      for (int k = 0; k < 3; k++) tick();
      cin_valid = 0;
      chk("t5_level_ovf", {level, ovf}, {5'd6, 1'b0});
      ready = 1;
      for (int k = 0; k < 6; k++) begin
         chk($sformatf("t5_drain%0d", k), {valid, sof, sol, eol, eof, data},
             {1'b1, tag_exp[k], 32'(500 + k)});
         tick();
      end
      chk("t5_empty", {valid, level}, {1'b0, 5'd0});
      cfg_en = 1; tick();
      cin_valid = 1; cin_data = 600; tick(); cin_valid = 0;
      chk("t5_reenable", {valid, sof, sol, data}, {1'b1, 2'b11, 32'd600});
      tick();

      // Test 6: async reset flushes FIFO and clears ovf
      ready = 0;
      for (int k = 0; k < 17; k++) begin
         cin_valid = 1; cin_data = 700 + k; tick();
      end
      cin_valid = 0; ready = 1;
      for (int k = 0; k < 11; k++) tick();
      ready = 0;
      chk("t6_pre_reset", {level, ovf}, {5'd5, 1'b1});
      #2 rst_n = 0;
      #1;
      chk("t6_async_reset", {valid, level, ovf}, {1'b0, 5'd0, 1'b0});
      @(negedge csi_clk); rst_n = 1;
      tick(); tick();
      for (int k = 0; k < 16; k++) begin
         cin_valid = 1; cin_data = 800 + k; tick();
      end
      ovf_clr = 1; cin_valid = 1; tick();
      chk("t6_clr_vs_drop", ovf, 1);
`ifdef CSI_CIN_FRAMER_DROP_CNT_EN
      chk("t6_drop_cnt_one", drop_cnt, 1);
`endif
      cin_valid = 0; tick(); ovf_clr = 0;
      chk("t6_clr_alone", ovf, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
